// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit registered ALU: widths and opcode map.
package alu_pkg;

    localparam int DW = 4;  // operand width
    localparam int RW = 5;  // result width (one extra bit for carry/borrow)

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_NOTB  = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational opcode decode and result mux for the ALU.
// Bit 4 of the result carries carry (ADD/INC), borrow (SUB) or 0 (logic ops).
module alu_core
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    sel,
    output logic [RW-1:0] y_next,
    output logic          zero_next
);

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Result mux; 5-bit unsigned wrap makes bit 4 of SUB the borrow (a < b).
    always_comb begin
        y_next = '0;
        case (sel)
            OP_ADD:   y_next = a_ext + b_ext;
            OP_SUB:   y_next = a_ext - b_ext;
            OP_INC:   y_next = a_ext + 5'd1;
            OP_NOTB:  y_next = {1'b0, ~b};
            OP_AND:   y_next = {1'b0, a & b};
            OP_OR:    y_next = {1'b0, a | b};
            OP_XOR:   y_next = {1'b0, a ^ b};
            OP_PASSA: y_next = a_ext;
            default:  y_next = '0;
        endcase
    end

    assign zero_next = (y_next == '0);

endmodule

// File: rtl/alu.sv
// Registered 4-bit ALU: one-cycle latency, full throughput, no handshake.
// The only state is the result register and its zero flag.
module alu
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    sel,
    output logic [RW-1:0] y,
    output logic          zero
);

    logic [RW-1:0] y_next;
    logic          zero_next;

    alu_core u_core (
        .a         (a),
        .b         (b),
        .sel       (sel),
        .y_next    (y_next),
        .zero_next (zero_next)
    );

    // Result/flag register; reset value is a zero result, so zero reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            zero <= 1'b1;
        end else begin
            y    <= y_next;
            zero <= zero_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU with a behavioural reference model.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [4:0] y;
    logic       zero;

    int checks;
    int failures;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .y     (y),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic from the opcode table.
    function automatic int model(input int ai, input int bi, input int s);
        case (s)
            0:       return ai + bi;
            1:       return (ai < bi) ? (ai - bi + 32) : (ai - bi);
            2:       return ai + 1;
            3:       return 15 - bi;
            4:       return ai & bi;
            5:       return ai | bi;
            6:       return ai ^ bi;
            default: return ai;
        endcase
    endfunction

    // Drive inputs away from the edge, then step past one rising edge.
    task automatic apply(input int ai, input int bi, input int s);
        @(negedge clk);
        a   = ai[3:0];
        b   = bi[3:0];
        sel = s[2:0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        a = 4'd9; b = 4'd3; sel = 3'b000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 5'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_async y=%0d zero=%0b expected y=0 zero=1", y, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 5'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold y=%0d zero=%0b expected y=0 zero=1", y, zero);
        end
        @(negedge clk);
        a = 4'd8; b = 4'd4; sel = 3'b000;
        rst_n = 1'b1;
        #1;
        checks++;
        if (y !== 5'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_pre_edge y=%0d zero=%0b expected y=0 zero=1", y, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 5'd12 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_op y=%0d zero=%0b expected y=12 zero=0", y, zero);
        end
    endtask

    task automatic test_add_sub;
        int vec[4][3] = '{'{10, 1, 0}, '{10, 1, 1}, '{7, 5, 1}, '{4, 8, 1}};
        int exp[4]    = '{11, 9, 2, 28};
        for (int i = 0; i < 4; i++) begin
            apply(vec[i][0], vec[i][1], vec[i][2]);
            checks++;
            if (y !== exp[i][4:0] || zero !== 1'b0) begin
                failures++;
                $display("FAIL add_sub[%0d] y=%0d zero=%0b expected y=%0d zero=0", i, y, zero, exp[i]);
            end
        end
    endtask

    task automatic test_inc_carry;
        int vec[3][3] = '{'{8, 0, 2}, '{15, 0, 2}, '{15, 15, 0}};
        int exp[3]    = '{9, 16, 30};
        for (int i = 0; i < 3; i++) begin
            apply(vec[i][0], vec[i][1], vec[i][2]);
            checks++;
            if (y !== exp[i][4:0] || zero !== 1'b0) begin
                failures++;
                $display("FAIL inc_carry[%0d] y=%0d zero=%0b expected y=%0d zero=0", i, y, zero, exp[i]);
            end
        end
    endtask

    task automatic test_notb;
        int bv[3]  = '{4, 0, 15};
        int exp[3] = '{11, 15, 0};
        logic ez;
        for (int i = 0; i < 3; i++) begin
            apply(6, bv[i], 3);
            ez = (exp[i] == 0);
            checks++;
            if (y !== exp[i][4:0] || zero !== ez) begin
                failures++;
                $display("FAIL notb[%0d] y=%0d zero=%0b expected y=%0d zero=%0b", i, y, zero, exp[i], ez);
            end
        end
    endtask

    task automatic test_logic;
        int exp[4] = '{8, 14, 6, 12};
        for (int i = 0; i < 4; i++) begin
            apply(12, 10, 4 + i);
            checks++;
            if (y !== exp[i][4:0] || zero !== 1'b0) begin
                failures++;
                $display("FAIL logic[%0d] y=%0d zero=%0b expected y=%0d zero=0", i, y, zero, exp[i]);
            end
        end
    endtask

    // New op every cycle; each result checked one cycle after its inputs.
    task automatic test_back_to_back;
        int exp[8] = '{12, 2, 8, 10, 5, 7, 2, 7};
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (y !== exp[i-1][4:0]) begin
                    failures++;
                    $display("FAIL back_to_back[%0d] y=%0d expected %0d", i - 1, y, exp[i-1]);
                end
            end
            if (i < 8) begin
                a = 4'd7; b = 4'd5; sel = i[2:0];
            end
        end
    endtask

    // Mid-cycle input glitches must not matter; only edge values count.
    task automatic test_random;
        int ai, bi, s, e;
        for (int i = 0; i < 200; i++) begin
            ai = $urandom_range(15);
            bi = $urandom_range(15);
            s  = $urandom_range(7);
            @(negedge clk);
            a = ai[3:0]; b = bi[3:0]; sel = s[2:0];
            @(posedge clk);
            #1;
            a = 4'($urandom); b = 4'($urandom); sel = 3'($urandom);
            #2;
            e = model(ai, bi, s);
            checks++;
            if (y !== e[4:0] || zero !== (e == 0)) begin
                failures++;
                $display("FAIL random[%0d] a=%0d b=%0d sel=%0d y=%0d zero=%0b expected y=%0d zero=%0b",
                         i, ai, bi, s, y, zero, e, (e == 0));
            end
        end
    endtask

    // Reset mid-operation drops the pending result; next edge uses current inputs.
    task automatic test_reset_midop;
        int e;
        apply(9, 3, 0);
        @(negedge clk);
        a = 4'd13; b = 4'd6; sel = 3'b001;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 5'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_midop_async y=%0d zero=%0b expected y=0 zero=1", y, zero);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = model(13, 6, 1);
        checks++;
        if (y !== e[4:0] || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop_first y=%0d zero=%0b expected y=%0d zero=0", y, zero, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        a = '0; b = '0; sel = '0;
        test_reset;
        test_add_sub;
        test_inc_carry;
        test_notb;
        test_logic;
        test_back_to_back;
        test_random;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
